// File: rtl/gcn_input_server.sv
// gcn_input_server: staging buffers (weights, features, COO edges) and run handshake for a GCN core.
// Define GCN_SERVER_RANGE_CHECK_EN to enable the sticky out-of-range read flag addr_err.
module gcn_input_server #(
    parameter int FEATURE_COLS      = 96,
    parameter int WEIGHT_ROWS       = 96,
    parameter int FEATURE_ROWS      = 6,
    parameter int WEIGHT_COLS       = 3,
    parameter int WEIGHT_WIDTH      = 5,
    parameter int ADDRESS_WIDTH     = 13,
    parameter int FEATURE_BASE      = 512,
    parameter int COO_NUM_OF_COLS   = 6,
    parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
    parameter int MAX_ADDRESS_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_start,
    input  logic [1:0]                   load_sel,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [WEIGHT_WIDTH-1:0]      load_data,
    output logic                         load_done,
    input  logic                         go,
    output logic                         gcn_start,
    input  logic [ADDRESS_WIDTH-1:0]     read_address,
    input  logic                         enable_read,
    output logic [WEIGHT_WIDTH-1:0]      data_out [0:WEIGHT_ROWS-1],
    input  logic [COO_BW-1:0]            coo_address,
    output logic [COO_BW-1:0]            coo_out [0:1],
    input  logic                         gcn_done,
    input  logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1],
    output logic [MAX_ADDRESS_WIDTH-1:0] result [0:FEATURE_ROWS-1],
    output logic                         result_valid,
    output logic                         addr_err
);
    localparam int MIN_N = (WEIGHT_ROWS > FEATURE_COLS) ? WEIGHT_ROWS : FEATURE_COLS;
    localparam int MAJ_N = (WEIGHT_COLS > FEATURE_ROWS) ? WEIGHT_COLS : FEATURE_ROWS;
    localparam int MIN_W = $clog2(MIN_N);
    localparam int MAJ_W = $clog2(MAJ_N);
    localparam int WC_W  = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
    localparam int FR_W  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;

    state_t state, state_nx;
    logic [1:0]       region;
    logic [MAJ_W-1:0] major, maj_last;
    logic [MIN_W-1:0] minor, min_last;
    logic [2:0]       loaded;
    logic             load_go, start_fire, beat, last_beat;
    logic             w_range, f_range, coo_hit;
    logic [ADDRESS_WIDTH-1:0] f_off;

    logic [WEIGHT_WIDTH-1:0] weights  [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1];
    logic [WEIGHT_WIDTH-1:0] features [0:FEATURE_ROWS-1][0:FEATURE_COLS-1];
    logic [COO_BW-1:0]       coo      [0:1][0:COO_NUM_OF_COLS-1];

    // A load request wins over go in the same cycle, since it invalidates a region.
    assign load_go    = (state == IDLE) && load_start && (load_sel != 2'd3);
    assign start_fire = (state == IDLE) && !load_go && go && (&loaded);
    assign beat       = (state == LOAD) && load_valid;
    assign last_beat  = beat && (minor == min_last) && (major == maj_last);
    assign load_ready = (state == LOAD);

    // Beats walk a (major, minor) pair: weight column/element, feature row/element, COO row/edge.
    always_comb begin
        min_last = MIN_W'(WEIGHT_ROWS - 1);
        maj_last = MAJ_W'(WEIGHT_COLS - 1);
        case (region)
            2'd1: begin
                min_last = MIN_W'(FEATURE_COLS - 1);
                maj_last = MAJ_W'(FEATURE_ROWS - 1);
            end
            2'd2: begin
                min_last = MIN_W'(COO_NUM_OF_COLS - 1);
                maj_last = MAJ_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (load_go)         state_nx = LOAD;
                else if (start_fire) state_nx = RUN;
            end
            LOAD:    if (last_beat) state_nx = IDLE;
            RUN:     if (gcn_done)  state_nx = CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            region       <= 2'd0;
            major        <= '0;
            minor        <= '0;
            loaded       <= 3'b000;
            load_done    <= 1'b0;
            gcn_start    <= 1'b0;
            result_valid <= 1'b0;
            for (int i = 0; i < FEATURE_ROWS; i++) result[i] <= '0;
        end else begin
            load_done <= last_beat;
            gcn_start <= start_fire;
            if (load_go) begin
                region          <= load_sel;
                major           <= '0;
                minor           <= '0;
                loaded[load_sel] <= 1'b0;
            end
            if (beat) begin
                if (minor == min_last) begin
                    minor <= '0;
                    major <= major + MAJ_W'(1);
                end else begin
                    minor <= minor + MIN_W'(1);
                end
            end
            if (last_beat) loaded[region] <= 1'b1;
            if (start_fire) result_valid <= 1'b0;
            if ((state == RUN) && gcn_done)
                for (int i = 0; i < FEATURE_ROWS; i++) result[i] <= max_addi_answer[i];
            if (state == CAPTURE) result_valid <= 1'b1;
        end
    end

    // Storage has no reset: loaded bits alone decide whether contents are usable.
    always_ff @(posedge clk) begin
        if (beat) begin
            case (region)
                2'd0:    weights[major[WC_W-1:0]][minor] <= load_data;
                2'd1:    features[major[FR_W-1:0]][minor] <= load_data;
                default: coo[major[0]][minor[COO_BW-1:0]] <= load_data[COO_BW-1:0];
            endcase
        end
    end

    assign w_range = int'(read_address) < WEIGHT_COLS;
    assign f_range = (int'(read_address) >= FEATURE_BASE) &&
                     (int'(read_address) < FEATURE_BASE + FEATURE_ROWS);
    assign f_off   = read_address - ADDRESS_WIDTH'(FEATURE_BASE);
    assign coo_hit = int'(coo_address) < COO_NUM_OF_COLS;

    always_comb begin
        for (int i = 0; i < WEIGHT_ROWS; i++) data_out[i] = '0;
        if (enable_read && w_range) begin
            for (int i = 0; i < WEIGHT_ROWS; i++)
                data_out[i] = weights[read_address[WC_W-1:0]][i];
        end else if (enable_read && f_range) begin
            for (int i = 0; i < FEATURE_COLS; i++)
                data_out[i] = features[f_off[FR_W-1:0]][i];
        end
    end

    assign coo_out[0] = coo_hit ? coo[0][coo_address] : '0;
    assign coo_out[1] = coo_hit ? coo[1][coo_address] : '0;

`ifdef GCN_SERVER_RANGE_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) addr_err <= 1'b0;
        else       addr_err <= (addr_err && !start_fire) ||
                               (enable_read && !w_range && !f_range) || !coo_hit;
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule
